// File: rtl/lsu_bridge_pkg.sv
// Shared types and helpers for the LSU-to-Wishbone bridge.
// The data memory has no byte selects, so partial stores are merged here.
package lsu_bridge_pkg;

  localparam int LANES = 4;
  localparam logic [LANES-1:0] BE_FULL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_bridge_state_t;

  // Lanes with be set come from new_word; the others keep old_word.
  function automatic logic [8*LANES-1:0] byte_merge(
    input logic [8*LANES-1:0] old_word,
    input logic [8*LANES-1:0] new_word,
    input logic [LANES-1:0]   be
  );
    logic [8*LANES-1:0] merged;
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsu_wishbone_bridge_timeout.sv
// Per-phase wait counter for Wishbone cycles; saturates at TIMEOUT_CYCLES.
// Held clear while no bus cycle is open, so each phase starts from zero.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/lsu_wishbone_bridge.sv
// Registers LSU requests onto a byte-select-free Wishbone-classic data bus,
// turning partial stores into read-modify-write pairs and aborting hung cycles.
module lsu_wishbone_bridge
  import lsu_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [LANES-1:0]      lsu_be_i,
  output logic                  lsu_ack_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i
);

  lsu_bridge_state_t     state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wb_cyc_o),
    .enable (wb_cyc_o && !wb_ack_i),
    .expired(expired)
  );

  assign wb_stb_o = wb_cyc_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lsu_ack_o   <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_err_o   <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
    end else begin
      lsu_ack_o   <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_err_o   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (lsu_req_i) begin
            wdata_q   <= lsu_wdata_i;
            be_q      <= lsu_be_i;
            wb_addr_o <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
            if (!lsu_we_i) begin
              state    <= ST_RD;
              wb_cyc_o <= 1'b1;
            end else if (lsu_be_i == BE_FULL) begin
              state     <= ST_WR;
              wb_cyc_o  <= 1'b1;
              wb_we_o   <= 1'b1;
              wb_data_o <= lsu_wdata_i;
            end else if (lsu_be_i == '0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_RMW_RD;
              wb_cyc_o <= 1'b1;
            end
          end
        end

        ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR: begin
          if (!wb_cyc_o) begin
            // Only RMW_WR arrives with cyc low: its write opens after one idle cycle.
            wb_cyc_o <= 1'b1;
            wb_we_o  <= 1'b1;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (state == ST_RD) rdata_q <= wb_data_i;
            if (state == ST_RMW_RD) begin
              wb_data_o <= byte_merge(wb_data_i, wdata_q, be_q);
              state     <= ST_RMW_WR;
            end else begin
              state <= ST_RESP;
            end
          end else if (expired) begin
            // Abort; a timed-out RMW read never reaches its write phase.
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            state    <= ST_RESP;
          end
        end

        ST_RESP: begin
          lsu_ack_o   <= 1'b1;
          lsu_rdata_o <= rdata_q;
          lsu_err_o   <= err_q;
          rdata_q     <= '0;
          err_q       <= 1'b0;
          wb_addr_o   <= '0;
          wb_data_o   <= '0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wishbone_bridge.sv
// Randomized bench for lsu_wishbone_bridge: a Wishbone memory responder with
// per-phase wait states plus a transaction-level reference model.
module tb_lsu_wishbone_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_i, lsu_we_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [3:0]  lsu_be_i;
  logic        lsu_ack_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  lsu_wishbone_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i),
    .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

  logic [31:0] slave_mem [logic [29:0]];
  logic [31:0] ref_mem   [logic [29:0]];
  bus_op_t     bus_log[$];
  int          wait_list [2];
  int          phases, cyc_cycles, stb_bad, wait_cnt, wait_cur;
  bit          no_ack, ack_real, prev_cyc;

  // Memory responder: acks after wait_list[phase] wait cycles, toggles ack
  // randomly while no cycle is open, and logs every acknowledged access.
  always @(negedge clk) begin
    bus_op_t op;
    if (wb_stb_o !== wb_cyc_o) stb_bad++;
    if (rst || !wb_cyc_o) begin
      ack_real  = 1'b0;
      wait_cnt  = 0;
      wb_ack_i  = 1'($urandom_range(0, 1));
      wb_data_i = $urandom;
    end else begin
      cyc_cycles++;
      if (!prev_cyc) begin
        wait_cur = wait_list[(phases > 1) ? 1 : phases];
        phases++;
        wait_cnt = 0;
      end
      if (ack_real) begin
        ack_real = 1'b0;
        wb_ack_i = 1'b0;
        wait_cnt = 0;
      end else if (no_ack || wait_cnt != wait_cur) begin
        wb_ack_i = 1'b0;
        wait_cnt++;
      end else begin
        wb_ack_i = 1'b1;
        ack_real = 1'b1;
        if (wb_we_o) begin
          slave_mem[wb_addr_o[31:2]] = wb_data_o;
          op = '{we: 1'b1, addr: wb_addr_o, data: wb_data_o};
        end else begin
          wb_data_i = slave_mem.exists(wb_addr_o[31:2]) ? slave_mem[wb_addr_o[31:2]] : 32'hDEAD_BEEF;
          op = '{we: 1'b0, addr: wb_addr_o, data: wb_data_i};
        end
        bus_log.push_back(op);
      end
    end
    prev_cyc = wb_cyc_o;
  end

  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    if (!ref_mem.exists(wa)) begin
      ref_mem[wa]   = $urandom;
      slave_mem[wa] = ref_mem[wa];
    end
    return ref_mem[wa];
  endfunction

  task automatic set_mem(input logic [31:0] addr, input logic [31:0] val);
    ref_mem[addr[31:2]]   = val;
    slave_mem[addr[31:2]] = val;
  endtask

  // Called at a negedge; returns at a negedge after the ack (and one more
  // cycle when the request is dropped).
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int w1, input int w2, input bit hang, input bit keep_req);
    logic [29:0] wa;
    logic [31:0] old, mask, merged, exp_rdata;
    logic        exp_err;
    bus_op_t     exp_ops[$];
    int          exp_lat, exp_phases, exp_cyc, n;
    bit          got;
    wa = addr[31:2];
    exp_rdata = '0;
    exp_err = 1'b0;
    if (we && be == 4'h0) begin
      exp_lat = 2; exp_phases = 0; exp_cyc = 0;
    end else begin
      old = ref_word(wa);
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
      merged = (wdata & mask) | (old & ~mask);
      if (hang) begin
        exp_lat = 3 + T; exp_phases = 1; exp_cyc = T + 1; exp_err = 1'b1;
      end else if (!we) begin
        exp_lat = 3 + w1; exp_phases = 1; exp_cyc = w1 + 1; exp_rdata = old;
        exp_ops.push_back('{we: 1'b0, addr: {wa, 2'b00}, data: old});
      end else if (be == 4'hF) begin
        exp_lat = 3 + w1; exp_phases = 1; exp_cyc = w1 + 1;
        exp_ops.push_back('{we: 1'b1, addr: {wa, 2'b00}, data: merged});
        ref_mem[wa] = merged;
      end else begin
        exp_lat = 5 + w1 + w2; exp_phases = 2; exp_cyc = w1 + w2 + 2;
        exp_ops.push_back('{we: 1'b0, addr: {wa, 2'b00}, data: old});
        exp_ops.push_back('{we: 1'b1, addr: {wa, 2'b00}, data: merged});
        ref_mem[wa] = merged;
      end
    end

    lsu_we_i = we; lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_be_i = be;
    lsu_req_i = 1'b1;
    no_ack = hang; wait_list[0] = w1; wait_list[1] = w2;
    bus_log.delete(); phases = 0; cyc_cycles = 0;

    n = 0; got = 0;
    while (n < 64) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (lsu_ack_o) begin
        got = 1;
        break;
      end
      // Scrambled core inputs mid-operation must not matter.
      lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
      lsu_be_i = 4'($urandom); lsu_we_i = 1'($urandom);
    end
    check({name, ":ack_seen"}, got, 1);
    check({name, ":latency"}, n, exp_lat);
    check({name, ":rdata"}, lsu_rdata_o, exp_rdata);
    check({name, ":err"}, lsu_err_o, exp_err);
    check({name, ":phases"}, phases, exp_phases);
    check({name, ":cyc_cycles"}, cyc_cycles, exp_cyc);
    check({name, ":op_count"}, bus_log.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < bus_log.size(); i++)
      check($sformatf("%s:op%0d", name, i), bus_log[i], exp_ops[i]);
    if (!keep_req) begin
      lsu_req_i = 1'b0;
      @(negedge clk);
      check({name, ":ack_one_cycle"}, lsu_ack_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        we;
    int          kind;

    rst = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0;
    lsu_wdata_i = '0; lsu_be_i = '0; no_ack = 0; wait_list[0] = 0; wait_list[1] = 0;
    phases = 0; cyc_cycles = 0; stb_bad = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {lsu_ack_o, lsu_rdata_o, lsu_err_o, wb_cyc_o, wb_stb_o,
                            wb_we_o, wb_addr_o, wb_data_o}, '0);
    rst = 1'b0;
    @(negedge clk);

    set_mem(32'h104, 32'hCAFE_BABE);
    run_txn("load_104", 1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 0);
    run_txn("full_store_200", 1'b1, 32'h200, 32'h1234_5678, 4'hF, 2, 0, 0, 0);
    set_mem(32'h300, 32'h1122_3344);
    run_txn("rmw_300", 1'b1, 32'h300, 32'h0000_AB00, 4'b0010, 0, 0, 0, 0);
    check("mem_300_after_rmw", slave_mem[30'h300 >> 2], 32'h1122_AB44);
    run_txn("load_timeout", 1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 1, 0);
    run_txn("rmw_timeout", 1'b1, 32'h300, 32'hFFFF_FFFF, 4'b0001, 0, 0, 1, 0);
    check("mem_300_after_timeout", slave_mem[30'h300 >> 2], 32'h1122_AB44);

    // Asynchronous reset in the middle of an RMW read phase.
    set_mem(32'h500, 32'hA5A5_5A5A);
    no_ack = 1; lsu_we_i = 1'b1; lsu_addr_i = 32'h500; lsu_wdata_i = 32'h00FF_0000;
    lsu_be_i = 4'b0100; lsu_req_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("rmw_cyc_before_rst", wb_cyc_o, 1);
    #1 rst = 1'b1;
    #1 check("rst_cyc_drop", wb_cyc_o, 0);
    check("rst_outputs", {lsu_ack_o, lsu_rdata_o, lsu_err_o, wb_cyc_o, wb_stb_o,
                          wb_we_o, wb_addr_o, wb_data_o}, '0);
    @(negedge clk);
    lsu_req_i = 1'b0; no_ack = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn("load_after_rst", 1'b0, 32'h500, 32'h0, 4'h0, 1, 0, 0, 0);

    // Request held high across consecutive transactions.
    run_txn("b2b_load0", 1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 1);
    run_txn("b2b_load1", 1'b0, 32'h300, 32'h0, 4'h0, 1, 0, 0, 1);
    run_txn("b2b_be0", 1'b1, 32'h200, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 1);
    run_txn("b2b_load2", 1'b0, 32'h200, 32'h0, 4'h0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 3);
      addr  = 32'h400 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      wdata = $urandom;
      we    = (kind != 0);
      case (kind)
        0:       be = 4'($urandom);
        1:       be = 4'hF;
        2:       be = 4'($urandom_range(1, 14));
        default: be = 4'h0;
      endcase
      run_txn($sformatf("rnd%0d", i), we, addr, wdata, be,
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      if (!lsu_req_i) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    lsu_req_i = 1'b0;
    @(negedge clk);

    check("stb_equals_cyc", stb_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_wishbone_bridge.md
Name: lsu_wishbone_bridge

Overview:
- Sits between the core's LSU request/ack port and the data-memory Wishbone-classic bus (data_mem_cyc/stb/we/addr/data/ack) served by the Controller's second memory.
- The Controller memory has no byte-select lines, so the block converts core byte-enable stores into read-modify-write (RMW) word cycles.
- Registers every request and aborts hung bus cycles with a timeout error.

Parameters:
- ADDR_WIDTH, 32, core and bus address width.
- DATA_WIDTH, 32, data width; fixed at 32, which gives 4 byte lanes.
- TIMEOUT_CYCLES, 255, wait cycles allowed for wb_ack_i per bus phase before abort.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- lsu_req_i  in  1  request level; held until lsu_ack_o.
- lsu_we_i  in  1  1 = store.
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data, lane-aligned.
- lsu_be_i  in  4  byte enables.
- lsu_ack_o  out  1  one-cycle completion pulse.
- lsu_rdata_o  out  32  load data, valid while lsu_ack_o=1.
- lsu_err_o  out  1  timeout flag, valid with lsu_ack_o.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o.
- wb_we_o  out  1  Wishbone write enable.
- wb_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- wb_data_o  out  32  write data.
- wb_data_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE and the timeout counter is cleared. Reset is asynchronous, so wb_cyc_o drops immediately even mid-cycle.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE, lsu_req_i=1: capture we/addr/wdata/be into registers. The captured registers are the only source for all later phases.
  - Load (we=0) -> RD.
  - Store with be=4'hF -> WR.
  - Store with be=4'h0 -> RESP; no bus access.
  - Any other store -> RMW_RD.
- RD, WR, RMW_RD, RMW_WR: wb_cyc_o, wb_stb_o and wb_addr_o are registered and asserted for the whole state. wb_we_o=1 in WR and RMW_WR only.
- Completion is the first cycle with wb_ack_i=1. On that edge:
  - RD: capture wb_data_i into the read register, go to RESP.
  - WR: go to RESP.
  - RMW_RD: merge, go to RMW_WR. For each lane i: merged[8i+7:8i] = be[i] ? wdata lane i : wb_data_i lane i. wb_data_o = merged in RMW_WR.
  - RMW_WR: go to RESP.
- wb_cyc_o deasserts on the cycle after the accepting ack. The two RMW phases are separate Wishbone cycles, with cyc low for one cycle between them.
- Timeout: an 8+ bit counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering each bus state and increments each cycle without ack.
  - When count==TIMEOUT_CYCLES without ack: drop cyc, set err, go to RESP, and set rdata to 0.
  - A timeout in RMW_RD skips RMW_WR, so memory is left unmodified.
- RESP: lsu_ack_o=1 for exactly one cycle, with lsu_rdata_o = the read register (0 for stores) and lsu_err_o = the err flag. Then go to IDLE. err and rdata clear on leaving RESP.
- Request timing:
  - lsu_req_i still high in the cycle after RESP is a new request, accepted in IDLE that cycle.
  - lsu_req_i is ignored outside IDLE; changes to core inputs mid-operation have no effect.
- Latency from the req-sampled edge to lsu_ack_o, with zero-wait ack (ack in the first cyc cycle):
  - load or full store: 3 cycles;
  - RMW store: 5 cycles;
  - be=0 store: 2 cycles.
  - Add slave wait states per phase.
- wb_ack_i while cyc=0 is ignored.
- Address bits [1:0] are not driven to the bus; lane selection is done by be only.
- Loads always read the full word; the core extracts lanes.

Decomposition:
- Package lsu_bridge_pkg holds:
  - the state enum lsu_bridge_state_t;
  - localparams LANES=4 and BE_FULL=4'hF;
  - function byte_merge(old, new, be).
- One natural sub-module: bus_timeout_counter, with clk, rst, clear, enable, expired outputs and TIMEOUT_CYCLES as a parameter. It is instantiated once and reused across phases.

Test Plan:
- Load at addr 0x0000_0104 with mem[0x104]=0xCAFEBABE and zero-wait ack -> wb_addr_o=0x104, wb_we_o=0 for one cycle. lsu_ack_o pulses 3 cycles after req, with rdata=0xCAFEBABE and err=0.
- Full store 0x12345678, be=F, to 0x200 with 2 wait states -> single write cycle with cyc high for 3 cycles, wb_data_o=0x12345678, ack 5 cycles after req.
- Partial store wdata=0x0000AB00, be=4'b0010, to 0x300 with mem=0x11223344 -> read cycle, one idle cycle, write of 0x1122AB44, then lsu_ack_o.
- Slave never acks with TIMEOUT_CYCLES=8 -> cyc drops after 8 wait cycles, lsu_ack_o=1 with err=1 and rdata=0. RMW case: no write phase is issued.
- rst asserted while cyc=1 mid-RMW -> wb_cyc_o=0 the same cycle (asynchronous), all outputs 0. After rst release, a new load completes normally.
- req held high across two loads, plus be=0 store -> back-to-back accepts with no lost or duplicated ack. The be=0 store acks in 2 cycles with no bus activity.
